// File: rtl/alu_pkg.sv
// Shared definitions for the two-port arbitrated ALU: operand width, opcode
// encodings, response flag bit positions and controller state encoding.
package alu_pkg;

  localparam int DATA_W = 4;
  localparam int FLAG_W = 3;

  // Bit positions inside the {sign, zero, carry} flag vector
  localparam int FLAG_CARRY = 0;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_SIGN  = 2;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } arb_state_e;

endpackage

// File: rtl/alu4_core.sv
// Combinational 4-bit ALU: add, subtract (carry = borrow), AND, OR, with
// carry/zero/sign flags derived from the 5-bit intermediate.
module alu4_core
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_e           op,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero,
  output logic              sign
);

  logic [DATA_W:0] wide;

  always_comb begin
    wide = '0;
    case (op)
      OP_ADD:  wide = {1'b0, a} + {1'b0, b};
      OP_SUB:  wide = {1'b0, a} - {1'b0, b};
      OP_AND:  wide = {1'b0, a & b};
      OP_OR:   wide = {1'b0, a | b};
      default: wide = '0;
    endcase
  end

  assign result = wide[DATA_W-1:0];
  assign carry  = wide[DATA_W];
  assign zero   = (result == '0);
  assign sign   = result[DATA_W-1];

endmodule

// File: rtl/alu_arb2.sv
// Two-requester round-robin arbiter in front of a single 4-bit ALU; one
// operation in flight, fixed two-cycle accept-to-response latency.
module alu_arb2
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  input  logic [2*NUM_REQ-1:0]      req_op,
  output logic                      rsp_valid,
  output logic                      rsp_id,
  output logic [DATA_W-1:0]         rsp_result,
  output logic [FLAG_W-1:0]         rsp_flags,
  input  logic                      rsp_ready
);

  arb_state_e        state;
  logic              ptr;
  logic [DATA_W-1:0] a_p0, b_p0;
  alu_op_e           op_p0;
  logic              id_p0;
  logic [DATA_W-1:0] result_p1;
  logic [FLAG_W-1:0] flags_p1;

  logic              gnt_vld;
  logic              gnt_id;
  logic [DATA_W-1:0] gnt_a, gnt_b;
  alu_op_e           gnt_op;

  logic [DATA_W-1:0] alu_result;
  logic              alu_carry, alu_zero, alu_sign;

  // Pointer only breaks ties; a lone requester wins whatever the pointer says
  always_comb begin
    gnt_vld = (state == ST_IDLE) && !rst && (req_valid != '0);
    gnt_id  = (req_valid == 2'b11) ? ptr : req_valid[1];
    gnt_a   = gnt_id ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
    gnt_b   = gnt_id ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
    gnt_op  = alu_op_e'(gnt_id ? req_op[3:2] : req_op[1:0]);
  end

  assign req_ready = gnt_vld ? (NUM_REQ'(1) << gnt_id) : '0;

  alu4_core u_alu (
    .a      (a_p0),
    .b      (b_p0),
    .op     (op_p0),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero),
    .sign   (alu_sign)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= 1'b0;
      a_p0      <= '0;
      b_p0      <= '0;
      op_p0     <= OP_ADD;
      id_p0     <= 1'b0;
      result_p1 <= '0;
      flags_p1  <= '0;
    end else begin
      case (state)
        // p0: capture the granted request
        ST_IDLE: if (gnt_vld) begin
          a_p0  <= gnt_a;
          b_p0  <= gnt_b;
          op_p0 <= gnt_op;
          id_p0 <= gnt_id;
          ptr   <= ~gnt_id;
          state <= ST_EXEC;
        end
        // p1: register ALU result and flags
        ST_EXEC: begin
          result_p1             <= alu_result;
          flags_p1[FLAG_SIGN]   <= alu_sign;
          flags_p1[FLAG_ZERO]   <= alu_zero;
          flags_p1[FLAG_CARRY]  <= alu_carry;
          state                 <= ST_RESP;
        end
        ST_RESP: if (rsp_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid  = (state == ST_RESP);
  assign rsp_id     = rsp_valid & id_p0;
  assign rsp_result = rsp_valid ? result_p1 : '0;
  assign rsp_flags  = rsp_valid ? flags_p1 : '0;

endmodule

// File: tb/tb_alu_arb2.sv
// Bench for alu_arb2: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a transaction-level reference model.
module tb_alu_arb2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_a, req_b;
  logic [3:0] req_op;
  logic       rsp_valid, rsp_id;
  logic [3:0] rsp_result;
  logic [2:0] rsp_flags;
  logic       rsp_ready;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 = free, 1 = op accepted last cycle, 2 = response due
  int         m_phase;
  int         m_ptr;
  logic [7:0] m_exp;          // {id, sign, zero, carry, result}
  logic [1:0] last_ready;
  logic [8:0] last_rsp;       // {valid, id, flags, result}
  int         grants[$];

  always #5 clk = ~clk;

  alu_arb2 #(.NUM_REQ(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .rsp_ready  (rsp_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {sign, zero, carry, result} from plain integer arithmetic
  function automatic logic [6:0] alu_ref(input int a, input int b, input int op);
    int r, c;
    case (op)
      0:       begin r = (a + b) % 16;      c = (a + b > 15) ? 1 : 0; end
      1:       begin r = (a - b + 16) % 16; c = (a < b) ? 1 : 0;      end
      2:       begin r = a & b;             c = 0;                    end
      default: begin r = a | b;             c = 0;                    end
    endcase
    return {r >= 8, r == 0, c != 0, 4'(r)};
  endfunction

  // One clock: sample/check at negedge, advance the model at posedge
  task automatic cycle();
    logic [1:0] exp_ready;
    logic [7:0] nxt;
    logic       rr;
    int         g;
    @(negedge clk);
    exp_ready = '0;
    g = 0;
    nxt = '0;
    rr = rsp_ready;
    if (!rst && m_phase == 0 && req_valid != 2'b00) begin
      g = (req_valid == 2'b11) ? m_ptr : (req_valid[1] ? 1 : 0);
      exp_ready[g] = 1'b1;
      nxt = {g[0], alu_ref(req_a[4*g +: 4], req_b[4*g +: 4], req_op[2*g +: 2])};
      grants.push_back(g);
    end
    last_ready = req_ready;
    last_rsp   = {rsp_valid, rsp_id, rsp_flags, rsp_result};
    check("req_ready", req_ready, exp_ready);
    if (m_phase == 2) check("rsp_fields", last_rsp, {1'b1, m_exp});
    else              check("rsp_quiet", last_rsp, 0);
    @(posedge clk);
    if (rst) begin
      m_phase = 0;
      m_ptr   = 0;
    end else if (m_phase == 0) begin
      if (exp_ready != 2'b00) begin
        m_phase = 1;
        m_ptr   = 1 - g;
        m_exp   = nxt;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (rr) begin
      m_phase = 0;
    end
    #1;
  endtask

  task automatic send(input int p, input logic [3:0] a, input logic [3:0] b,
                      input logic [1:0] op, input logic [6:0] exp_rsp);
    int n;
    req_a[4*p +: 4]  = a;
    req_b[4*p +: 4]  = b;
    req_op[2*p +: 2] = op;
    req_valid[p]     = 1'b1;
    rsp_ready        = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_ready[p] && n < 20);
    check("grant_seen", last_ready[p], 1);
    req_valid[p] = 1'b0;
    cycle();
    cycle();
    check("rsp_directed", last_rsp, {1'b1, p[0], exp_rsp});
  endtask

  task automatic idle_cycles(input int n);
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    logic [8:0] snap;
    rst       = 1'b1;
    req_valid = 2'b00;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    m_phase   = 0;
    m_ptr     = 0;
    m_exp     = '0;
    @(posedge clk);
    #1;

    // Reset: requests present but nothing may be accepted
    req_valid = 2'b11;
    cycle();
    check("reset_ready", last_ready, 0);
    check("reset_rsp", last_rsp, 0);
    req_valid = 2'b00;
    cycle();
    rst = 1'b0;

    // Directed ALU cases
    send(0, 4'h9, 4'h8, 2'b00, 7'b001_0001);
    send(1, 4'h3, 4'h5, 2'b01, 7'b101_1110);
    send(0, 4'hC, 4'h3, 2'b10, 7'b010_0000);
    send(0, 4'hC, 4'h3, 2'b11, 7'b100_1111);

    // Both ports continuously valid from reset: grants alternate
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    grants.delete();
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      cycle();
      check("one_hot", ($countones(last_ready) <= 1) ? 1 : 0, 1);
    end
    check("rr_count", (grants.size() >= 4) ? 1 : 0, 1);
    for (int k = 0; k < 4 && k < grants.size(); k++) check("rr_order", grants[k], k % 2);
    idle_cycles(4);

    // Stalled response stays stable; pending port 1 served after handshake
    rsp_ready = 1'b0;
    req_a[3:0] = 4'h7; req_b[3:0] = 4'h7; req_op[1:0] = 2'b01;
    req_valid = 2'b01;
    cycle();
    check("stall_grant", last_ready, 2'b01);
    req_valid = 2'b10;
    cycle();
    cycle();
    snap = last_rsp;
    check("stall_valid", snap[8], 1);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("stall_stable", last_rsp, snap);
      check("stall_ready", last_ready, 0);
    end
    rsp_ready = 1'b1;
    cycle();
    cycle();
    check("pending_served", last_ready, 2'b10);
    idle_cycles(4);

    // Reset during RESP drops the response and restores pointer to port 0
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    cycle();
    check("abort_grant", last_ready, 2'b01);
    req_valid = 2'b00;
    cycle();
    rst = 1'b1;
    cycle();
    check("abort_in_resp", last_rsp[8], 1);
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("abort_dropped", last_rsp[8], 0);
    end
    req_valid = 2'b11;
    cycle();
    check("abort_ptr", last_ready, 2'b01);
    idle_cycles(4);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (last_ready[p]) req_valid[p] = 1'b0;
        if (!req_valid[p] && $urandom_range(0, 2) == 0) begin
          req_valid[p]     = 1'b1;
          req_a[4*p +: 4]  = 4'($urandom);
          req_b[4*p +: 4]  = 4'($urandom);
          req_op[2*p +: 2] = 2'($urandom);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 49) == 0);
      cycle();
    end
    rst = 1'b0;
    idle_cycles(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arb2.md
ALU_ARB2 -- requirements
Module: alu_arb2

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, meaning number of requester ports; only value 2 is supported.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous reset, active-high.
REQ-004 The block SHALL have port req_valid  input  2  per-port request valid, bit i = port i.
REQ-005 The block SHALL have port req_ready  output  2  per-port request accepted this cycle, one-hot or zero.
REQ-006 The block SHALL have port req_a  input  8  operand A, bits [4i+3:4i] for port i.
REQ-007 The block SHALL have port req_b  input  8  operand B, bits [4i+3:4i] for port i.
REQ-008 The block SHALL have port req_op  input  4  opcode, bits [2i+1:2i] for port i.
REQ-009 The block SHALL have port rsp_valid  output  1  response valid.
REQ-010 The block SHALL have port rsp_id  output  1  port index the response belongs to.
REQ-011 The block SHALL have port rsp_result  output  4  ALU result.
REQ-012 The block SHALL have port rsp_flags  output  3  {sign, zero, carry}.
REQ-013 The block SHALL have port rsp_ready  input  1  consumer accepts response.

Function
REQ-014 The block SHALL implement FSM states IDLE, EXEC, RESP; one operation in flight at a time.
REQ-015 In IDLE with any req_valid set, the block SHALL grant one port, assert its req_ready combinationally that cycle, capture its a/b/op/id, and go to EXEC.
REQ-016 Grant SHALL be round-robin: pointer names the preferred port; if only one port valid it wins regardless of pointer.
REQ-017 The pointer SHALL move to the port other than the granted one on each grant; it SHALL NOT change without a grant.
REQ-018 req_ready SHALL be zero in EXEC and RESP.
REQ-019 In EXEC the block SHALL compute the ALU function on captured operands, register result and flags, and go to RESP.
REQ-020 In RESP rsp_valid SHALL be 1 and rsp_id/rsp_result/rsp_flags SHALL hold stable until the cycle rsp_valid and rsp_ready are both 1, after which the state SHALL be IDLE.
REQ-021 Latency: request accepted in cycle N SHALL produce rsp_valid in cycle N+2; minimum throughput one operation per 3 cycles.
REQ-022 Op 00: {carry,result} = a + b as 5-bit sum.
REQ-023 Op 01: {carry,result} = a - b modulo 32, carry = bit 4 (borrow, 1 when a < b).
REQ-024 Op 10: result = a AND b, carry 0; op 11: result = a OR b, carry 0.
REQ-025 zero SHALL be 1 iff result == 0; sign SHALL equal result[3].
REQ-026 Requests presented during EXEC/RESP SHALL be ignored (not captured) and remain pending until granted in IDLE.
REQ-027 rsp_valid, rsp_id, rsp_result, rsp_flags SHALL be zero outside RESP.

Reset
REQ-028 With rst=1 at a clock edge: state IDLE, pointer = port 0, captured operands/result/flags zero, all outputs zero, effective next cycle.
REQ-029 Reset asserted in EXEC or RESP SHALL abandon the operation; no response for it SHALL ever be issued.
REQ-030 req_ready SHALL be 0 in any cycle rst is 1.

Structure
REQ-031 Opcode encodings (ADD, SUB, AND, OR), flag bit positions and FSM state encoding SHALL live in shared package alu_pkg.
REQ-032 The combinational ALU function SHALL be sub-module alu4_core (a, b, op -> result, carry, zero, sign), instantiated once.

Verification
REQ-033 Port 0 only, a=9, b=8, op=00 -> rsp at N+2: id 0, result 1, flags carry 1, zero 0, sign 0.
REQ-034 Port 1 only, a=3, b=5, op=01 -> result 14, carry 1, sign 1, zero 0, id 1.
REQ-035 Port 0, a=0xC, b=0x3, op=10 -> result 0, zero 1, carry 0; then op=11 same operands -> result 0xF, sign 1.
REQ-036 Both ports valid continuously after reset, rsp_ready=1 -> grants alternate 0,1,0,1; req_ready never two-hot.
REQ-037 rsp_ready held 0 for 5 cycles in RESP -> rsp fields stable, req_ready 0 throughout, pending request served after handshake.
REQ-038 rst pulsed in RESP -> rsp_valid 0 next cycle, state IDLE, pointer port 0, dropped response never appears.
